// File: rtl/udp_rx_parser_if.sv
// IP RX -> UDP RX stream bundle. The upstream IPv4 layer drives through the
// master view; the UDP parser consumes it through the slave view.
interface udp_rx_parser_if;
  logic        ip_rx_start;
  logic [7:0]  ip_rx_protocol;
  logic [31:0] ip_rx_src_ip;
  logic [7:0]  ip_rx_data_in;
  logic        ip_rx_data_in_valid;
  logic        ip_rx_data_in_last;

  logic        udp_rx_start;
  logic [31:0] udp_rx_src_ip;
  logic [15:0] udp_rx_src_port;
  logic [15:0] udp_rx_dst_port;
  logic [15:0] udp_rx_data_length;
  logic [7:0]  udp_rx_data_out;
  logic        udp_rx_data_out_valid;
  logic        udp_rx_data_out_last;
  logic        udp_rx_error;

  modport master (
    output ip_rx_start, ip_rx_protocol, ip_rx_src_ip,
           ip_rx_data_in, ip_rx_data_in_valid, ip_rx_data_in_last,
    input  udp_rx_start, udp_rx_src_ip, udp_rx_src_port, udp_rx_dst_port,
           udp_rx_data_length, udp_rx_data_out, udp_rx_data_out_valid,
           udp_rx_data_out_last, udp_rx_error
  );

  modport slave (
    input  ip_rx_start, ip_rx_protocol, ip_rx_src_ip,
           ip_rx_data_in, ip_rx_data_in_valid, ip_rx_data_in_last,
    output udp_rx_start, udp_rx_src_ip, udp_rx_src_port, udp_rx_dst_port,
           udp_rx_data_length, udp_rx_data_out, udp_rx_data_out_valid,
           udp_rx_data_out_last, udp_rx_error
  );
endinterface

// File: rtl/udp_rx_parser.sv
// UDP receive parser: strips the 8-byte UDP header from the IPv4 RX payload
// stream, publishes the decoded header and forwards the payload with a fixed
// one-cycle latency. Push-only, no backpressure.
module udp_rx_parser #(
  parameter bit          PORT_FILTER_EN = 1'b0,
  parameter logic [15:0] LISTEN_PORT    = 16'h0000
) (
  input  logic            clk,
  input  logic            reset,
  udp_rx_parser_if.slave  bus
);

  localparam logic [7:0] PROTO_UDP = 8'h11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    DATA    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state_r;
  logic [2:0]  hdr_cnt_r;
  logic [15:0] pay_cnt_r;
  logic [31:0] src_ip_r;
  logic [15:0] src_port_r;
  logic [15:0] dst_port_r;
  logic [15:0] length_r;

  // Published outputs; header fields are only refreshed on a start pulse.
  logic        start_r;
  logic [31:0] src_ip_out_r;
  logic [15:0] src_port_out_r;
  logic [15:0] dst_port_out_r;
  logic [15:0] data_len_out_r;
  logic [7:0]  data_out_r;
  logic        data_valid_r;
  logic        data_last_r;
  logic        error_r;

  logic [15:0] payload_len_s;
  logic        len_short_s;
  logic        port_reject_s;
  logic [15:0] pay_cnt_next_s;
  logic        count_done_s;

  // Header decode and payload-count helpers, evaluated against the stored header.
  always_comb begin
    payload_len_s  = length_r - 16'd8;
    len_short_s    = (length_r < 16'd8);
    port_reject_s  = PORT_FILTER_EN && (dst_port_r != LISTEN_PORT);
    pay_cnt_next_s = pay_cnt_r + 16'd1;
    count_done_s   = (pay_cnt_next_s == data_len_out_r);
  end

  // Parser FSM with all outputs registered; a new start always wins and aborts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= IDLE;
      hdr_cnt_r      <= 3'd0;
      pay_cnt_r      <= 16'd0;
      src_ip_r       <= 32'd0;
      src_port_r     <= 16'd0;
      dst_port_r     <= 16'd0;
      length_r       <= 16'd0;
      start_r        <= 1'b0;
      src_ip_out_r   <= 32'd0;
      src_port_out_r <= 16'd0;
      dst_port_out_r <= 16'd0;
      data_len_out_r <= 16'd0;
      data_out_r     <= 8'd0;
      data_valid_r   <= 1'b0;
      data_last_r    <= 1'b0;
      error_r        <= 1'b0;
    end else begin
      start_r      <= 1'b0;
      data_valid_r <= 1'b0;
      data_last_r  <= 1'b0;
      error_r      <= 1'b0;
      if (bus.ip_rx_start) begin
        // A start outside IDLE means the previous datagram never saw its last byte.
        error_r   <= (state_r != IDLE);
        src_ip_r  <= bus.ip_rx_src_ip;
        hdr_cnt_r <= 3'd0;
        pay_cnt_r <= 16'd0;
        state_r   <= (bus.ip_rx_protocol == PROTO_UDP) ? HDR : DISCARD;
      end else if (bus.ip_rx_data_in_valid) begin
        case (state_r)
          HDR: begin
            case (hdr_cnt_r)
              3'd0:    src_port_r[15:8] <= bus.ip_rx_data_in;
              3'd1:    src_port_r[7:0]  <= bus.ip_rx_data_in;
              3'd2:    dst_port_r[15:8] <= bus.ip_rx_data_in;
              3'd3:    dst_port_r[7:0]  <= bus.ip_rx_data_in;
              3'd4:    length_r[15:8]   <= bus.ip_rx_data_in;
              3'd5:    length_r[7:0]    <= bus.ip_rx_data_in;
              default: ; // checksum bytes are consumed but not verified
            endcase
            hdr_cnt_r <= hdr_cnt_r + 3'd1;
            if (hdr_cnt_r == 3'd7) begin
              if (len_short_s) begin
                error_r <= 1'b1;
                state_r <= bus.ip_rx_data_in_last ? IDLE : DISCARD;
              end else if (port_reject_s) begin
                state_r <= bus.ip_rx_data_in_last ? IDLE : DISCARD;
              end else begin
                start_r        <= 1'b1;
                src_ip_out_r   <= src_ip_r;
                src_port_out_r <= src_port_r;
                dst_port_out_r <= dst_port_r;
                data_len_out_r <= payload_len_s;
                pay_cnt_r      <= 16'd0;
                if (bus.ip_rx_data_in_last) begin
                  // Header-only datagram is truncated unless it declares no payload.
                  error_r <= (payload_len_s != 16'd0);
                  state_r <= IDLE;
                end else if (payload_len_s == 16'd0) begin
                  state_r <= DISCARD;
                end else begin
                  state_r <= DATA;
                end
              end
            end else if (bus.ip_rx_data_in_last) begin
              error_r <= 1'b1;
              state_r <= IDLE;
            end else begin
              state_r <= HDR;
            end
          end
          DATA: begin
            data_out_r   <= bus.ip_rx_data_in;
            data_valid_r <= 1'b1;
            pay_cnt_r    <= pay_cnt_next_s;
            data_last_r  <= count_done_s | bus.ip_rx_data_in_last;
            if (bus.ip_rx_data_in_last) begin
              error_r <= ~count_done_s;
              state_r <= IDLE;
            end else if (count_done_s) begin
              // Remaining IP payload is Ethernet padding.
              state_r <= DISCARD;
            end else begin
              state_r <= DATA;
            end
          end
          DISCARD: begin
            state_r <= bus.ip_rx_data_in_last ? IDLE : DISCARD;
          end
          default: ; // IDLE ignores bytes that arrive without a start
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign bus.udp_rx_start          = start_r;
  assign bus.udp_rx_src_ip         = src_ip_out_r;
  assign bus.udp_rx_src_port       = src_port_out_r;
  assign bus.udp_rx_dst_port       = dst_port_out_r;
  assign bus.udp_rx_data_length    = data_len_out_r;
  assign bus.udp_rx_data_out       = data_out_r;
  assign bus.udp_rx_data_out_valid = data_valid_r;
  assign bus.udp_rx_data_out_last  = data_last_r;
  assign bus.udp_rx_error          = error_r;

endmodule

// File: doc/udp_rx_parser.md
Name: udp_rx_parser

Overview:
- Receive-side counterpart of the UDP TX path: consumes the IPv4 RX byte stream plus IP header fields, strips and decodes the 8-byte UDP header, and presents the UDP header and payload stream to the application.
- Sits between the IPv4 RX layer and the user/application RX logic.
- Push-only stream with no backpressure, matching the IP RX layer.

Parameters:
- PORT_FILTER_EN, 0, 1 = drop datagrams whose destination port differs from LISTEN_PORT.
- LISTEN_PORT, 16'h0000, destination port accepted when PORT_FILTER_EN=1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- ip_rx_start  input  1  one-cycle pulse: IP header fields valid, datagram payload follows.
- ip_rx_protocol  input  8  IP protocol field; sampled on ip_rx_start.
- ip_rx_src_ip  input  32  IP source address; sampled on ip_rx_start.
- ip_rx_data_in  input  8  IP payload byte.
- ip_rx_data_in_valid  input  1  payload byte valid.
- ip_rx_data_in_last  input  1  final IP payload byte; qualified by valid.
- udp_rx_start  output  1  one-cycle pulse: udp_rx header outputs valid.
- udp_rx_src_ip  output  32  source IP of current datagram.
- udp_rx_src_port  output  16  UDP source port.
- udp_rx_dst_port  output  16  UDP destination port.
- udp_rx_data_length  output  16  payload length = UDP length − 8.
- udp_rx_data_out  output  8  payload byte.
- udp_rx_data_out_valid  output  1  payload byte valid.
- udp_rx_data_out_last  output  1  final payload byte.
- udp_rx_error  output  1  one-cycle pulse on malformed/truncated datagram.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters 0. Mid-datagram reset abandons the datagram with no last and no error.
- States: IDLE, HDR, DATA, DISCARD.
- IDLE:
  - ip_rx_start with protocol 8'h11: latch src_ip, go to HDR with byte count 0.
  - Any other protocol: go to DISCARD.
  - Valid bytes without a start are ignored.
- HDR: each valid byte is stored big-endian.
  - Bytes 0–1: src port. Bytes 2–3: dst port. Bytes 4–5: length. Bytes 6–7: checksum (ignored, not verified).
  - On byte 7:
    - length < 8: error pulse next cycle, go to DISCARD (or IDLE if byte 7 is also last).
    - Port filter mismatch: go to DISCARD silently, no start.
    - Otherwise: next cycle, udp_rx_start=1 for one cycle with all header outputs valid; data_length = length − 8 (16-bit, no wrap, since length ≥ 8). Go to DATA, or to DISCARD/IDLE when data_length = 0.
- Header outputs hold their values until the next udp_rx_start.
- DATA:
  - Each valid input byte appears on udp_rx_data_out with valid=1 exactly one cycle later (registered, 1-cycle latency). Gaps in input valid are reproduced.
  - Payload counter counts forwarded bytes.
  - udp_rx_data_out_last=1 on the byte where count reaches data_length, or on a byte carrying ip last, whichever comes first.
  - Count reached with ip last not yet seen (Ethernet padding): go to DISCARD.
  - Both conditions on the same byte: normal end, go to IDLE.
  - ip last before data_length reached (truncation): last=1 on that byte and udp_rx_error=1 in the same cycle; go to IDLE.
- ip last arriving during HDR before byte 7 (short datagram): error pulse, no start, go to IDLE.
- DISCARD: consume valid bytes with no outputs; go to IDLE on ip last.
- ip_rx_start in a non-IDLE state (new datagram before old last): abort the current datagram, pulse udp_rx_error, restart parsing from HDR with the new fields. Last is not emitted for the aborted datagram.
- Valid, last and error are never held for more than one cycle per event.

Test Plan:
- Nominal: protocol 0x11; header 04 D2 00 50 00 0C 00 00 then payload AA BB CC DD with last on DD → start pulse with src_port 1234, dst_port 80, data_length 4; four output bytes each 1 cycle after input; last on DD; no error.
- Padding: length 0x000A, payload 11 22 plus 4 pad bytes, ip last on the final pad → output 11 22 with last on 22; pad bytes not output; FSM returns to IDLE after ip last.
- Truncation: length 0x0010 (8 payload bytes) but ip last after 3 payload bytes → last on 3rd byte with udp_rx_error pulse in the same cycle.
- Filtering:
  - Protocol 0x06 → no start, no output, no error.
  - PORT_FILTER_EN=1, LISTEN_PORT=80 with dst port 81 → silently dropped.
  - Same setup with dst port 80 → normal.
- Malformed: length 0x0005 → error pulse, no start. ip last on header byte 4 → error, no start.
- Reset/abort:
  - Assert reset mid-payload → all outputs 0 immediately; next datagram parses correctly.
  - New ip_rx_start mid-DATA → error pulse, then the new datagram's start.
